regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the RISC-V core with configurable width, depth, and read/write port counts.
- Optional write-to-read bypass.
- Hardwired zero register.
- Per-register busy scoreboard: issue reserves a destination, write-back releases it.
- After reset, a sequential clear sweep makes the array BRAM/LUTRAM friendly; no single-cycle reset of the whole array.
- Sits between decode (reads, reserve) and write-back (writes).

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_READ, 2, number of combinational read ports
NUM_WRITE, 1, number of write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
ADDR_WIDTH, $clog2(NUM_REGS), derived; not to be overridden

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
init_done  output  1  high once clear sweep complete
rd_addr  input  NUM_READ x ADDR_WIDTH  read addresses
rd_data  output  NUM_READ x DATA_WIDTH  read data, combinational
rd_ready  output  NUM_READ  operand valid (not busy, or bypassed this cycle)
wr_en  input  NUM_WRITE  write enables
wr_addr  input  NUM_WRITE x ADDR_WIDTH  write addresses
wr_data  input  NUM_WRITE x DATA_WIDTH  write data
rsv_en  input  1  reserve destination (mark busy)
rsv_addr  input  ADDR_WIDTH  register to reserve
busy_vec  output  NUM_REGS  current busy bits

Behaviour:
Interface: one clock, `clk`; reset is synchronous and active-high, named `reset`.

State machine and reset:
- States are INIT and RUN. Reset has priority over everything.
- reset=1 at an edge → next state INIT, sweep counter=0, busy_vec=0, init_done=0. This applies from any state, including mid-sweep and mid-RUN.
- INIT: each cycle writes 0 to reg[counter] and increments counter. At counter==NUM_REGS-1 the next state is RUN.
- init_done=1 exactly NUM_REGS rising edges after the first edge with reset=0.
- During INIT:
  - wr_en and rsv_en are ignored.
  - rd_data=0, rd_ready=0.
  - busy_vec is held at 0.

RUN, writes:
- Write occurs at the edge where wr_en[j]=1.
- With ZERO_REG=1, wr_addr==0 is dropped.
- Multiple ports to the same address in the same cycle: the highest port index wins.

RUN, reads (combinational, zero latency):
- rd_data[i] priority:
  - ZERO_REG and rd_addr==0 → 0.
  - Otherwise BYPASS and any wr_en[j] with wr_addr[j]==rd_addr[i] → wr_data of the highest such j.
  - Otherwise reg[rd_addr[i]].
- With BYPASS=0, a read of a same-cycle write returns the old value; the new value is visible the next cycle.
- rd_ready[i] = !busy[rd_addr[i]], or a bypass hit this cycle, or the zero register.

Busy scoreboard, next-state per register r:
- rsv_en && rsv_addr==r → 1. This holds even if r is being written the same cycle: the new reservation wins over the old write-back.
- Otherwise, any wr_en with wr_addr==r → 0.
- Otherwise hold.
- ZERO_REG=1: busy[0] is constantly 0.
- A write to a non-busy register is legal: the data is stored and the busy bit stays 0.
- A reserve of an already busy register is legal and it stays 1.

Outputs:
- busy_vec is registered. A reservation is visible on busy_vec and rd_ready one cycle after rsv_en.

Width rules:
- Addresses are ADDR_WIDTH exact; no wrap beyond NUM_REGS (power-of-two constraint).
- Data is stored unmodified.

Decomposition:
- Shared package regfile_pkg holds:
  - regfile_state_e enum {INIT, RUN};
  - default width/depth constants;
  - a helper function for highest-index write-port match (used by both storage and bypass).
- Natural sub-module: regfile_scoreboard, which owns the busy bits, the reserve/release priority, and the zero-register mask.
- Array, sweep FSM and read muxing stay in the top level.

Test Plan:
1. Reset sweep: reset=1 for 2 cycles then 0, defaults → init_done low for exactly 32 edges, then high; all 32 registers read 0; rd_ready=0 during INIT; wr_en pulsed during INIT is ignored (reg reads 0 after).
2. Write/read and zero register: write 0xDEADBEEF to x5, then 0x12345678 to x0 → next cycle rd_addr=5 gives 0xDEADBEEF; rd_addr=0 gives 0; busy_vec[0]=0 throughout.
3. Bypass and priority: NUM_WRITE=2, BYPASS=1, port0 writes 0xAAAA to x7 and port1 writes 0xBBBB to x7 in the same cycle, rd_addr=7 → same-cycle rd_data=0xBBBB, stored value 0xBBBB. Repeat with BYPASS=0 → same cycle returns old value, next cycle 0xBBBB.
4. Scoreboard: rsv x9 → next cycle busy_vec[9]=1 and rd_ready=0 for x9; write 0x55 to x9 → same cycle rd_ready=1 (bypass); next cycle busy_vec[9]=0.
5. Simultaneous reserve and release: rsv_en and wr_en both on x3 in the same cycle → busy_vec[3]=1 next cycle; data=written value.
6. Reset mid-operation: in RUN, x4 busy holding 0x77, assert reset for 1 cycle → busy_vec=0, init_done=0, full 32-cycle sweep repeats, x4 reads 0 after.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// Holds the sweep FSM states and the write-port priority helper.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regfile_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_READ   = 2;
  localparam int MAX_WRITE      = 4;

  // Index of the highest write port whose match bit is set.
  // Later ports take priority, so the last hit scanned wins.
  function automatic logic [1:0] hi_port(
    input logic [MAX_WRITE-1:0] hits
  );
    logic [1:0] idx;
    idx = '0;
    for (int j = 0; j < MAX_WRITE; j++) begin
      if (hits[j]) idx = 2'(j);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Reserve sets a bit, write-back clears it, reserve wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic                            rsv_en,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  output logic [NUM_REGS-1:0]             busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy bits: release on write-back, then reserve overrides.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] &&
              wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
              ADDR_WIDTH'(r)) begin
            busy_d[r] = 1'b0;
          end
        end
        if (rsv_en && rsv_addr == ADDR_WIDTH'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end else begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy register; cleared by reset and held clear while sweeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with clear sweep, bypass and zero reg.
// Array, sweep FSM and read muxing live here; busy bits in scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int NUM_READ   = DEF_NUM_READ,
  parameter  int NUM_WRITE  = 1,
  parameter  int BYPASS     = 1,
  parameter  int ZERO_REG   = 1,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            init_done,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_ready,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                            rsv_en,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  output logic [NUM_REGS-1:0]             busy_vec
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  regfile_state_e state_q;
  regfile_state_e state_d;
  logic [AW-1:0]  cnt_q;
  logic [AW-1:0]  cnt_d;
  logic           run;
  logic           sweep_we;
  logic [NUM_WRITE-1:0] wr_ok;
  logic [DW-1:0]  mem_q [NUM_REGS];

  // Sweep state and counter register; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every register once, then enter RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_REGS - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs: sweep write strobe and the run/done flags.
  always_comb begin
    run       = (state_q == RUN);
    sweep_we  = (state_q == INIT);
    init_done = run;
  end

  // Qualified write enables: RUN only, zero register drops writes.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      wr_ok[j] = run && wr_en[j] &&
        !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0);
    end
  end

  // Storage without array reset; later ports land last and win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (sweep_we) mem_q[cnt_q] <= '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_ok[j]) begin
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG),
    .ADDR_WIDTH (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [AW-1:0]        ra;
    logic [MAX_WRITE-1:0] hits;
    logic [1:0]           hp;
    logic [DW-1:0]        dat;
    logic                 rdy;

    assign ra = rd_addr[g*AW +: AW];
    assign hp = hi_port(hits);

    // Write ports addressing this read port in the current cycle.
    always_comb begin
      hits = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        hits[j] = wr_en[j] && (wr_addr[j*AW +: AW] == ra);
      end
    end

    // Operand mux: zero reg, then bypass, then array contents.
    always_comb begin
      dat = '0;
      rdy = 1'b0;
      if (run) begin
        if (ZERO_REG != 0 && ra == '0) begin
          rdy = 1'b1;
        end else if (BYPASS != 0 && |hits) begin
          dat = wr_data[int'(hp)*DW +: DW];
          rdy = 1'b1;
        end else begin
          dat = mem_q[ra];
          rdy = !busy_vec[ra];
        end
      end
    end

    assign rd_data[g*DW +: DW] = dat;
    assign rd_ready[g]         = rdy;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport.
// Runs a bypass and a non-bypass instance on shared stimulus.
module tb_regfile_multiport;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;

  logic               done_b, done_n;
  logic [NRD*DW-1:0]  data_b, data_n;
  logic [NRD-1:0]     rdy_b, rdy_n;
  logic [NR-1:0]      busy_b, busy_n;

  regfile_multiport #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .NUM_READ (NRD),
    .NUM_WRITE (NWR), .BYPASS (1), .ZERO_REG (1)
  ) dut (
    .clk (clk), .reset (reset), .init_done (done_b),
    .rd_addr (rd_addr), .rd_data (data_b), .rd_ready (rdy_b),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .rsv_en (rsv_en), .rsv_addr (rsv_addr), .busy_vec (busy_b)
  );

  regfile_multiport #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .NUM_READ (NRD),
    .NUM_WRITE (NWR), .BYPASS (0), .ZERO_REG (1)
  ) dut_nb (
    .clk (clk), .reset (reset), .init_done (done_n),
    .rd_addr (rd_addr), .rd_data (data_n), .rd_ready (rdy_n),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .rsv_en (rsv_en), .rsv_addr (rsv_addr), .busy_vec (busy_n)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m [NR];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    sbq.push_back('{tag, exp});
  endtask

  task automatic pop(input logic [63:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL sb_underflow: got %0h want none", obs);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  function automatic logic [DW-1:0] pd(
    input logic [NRD*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  initial begin
    logic [AW-1:0] a, ra;
    logic [DW-1:0] d;

    reset   = 1'b1;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_addr = '0;
    for (int r = 0; r < NR; r++) m[r] = '0;

    // reset held for two edges
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    push("rst_done", 0);    pop(done_b);
    push("rst_done_nb", 0); pop(done_n);
    push("rst_busy", 0);    pop(busy_b);
    reset = 1'b0;

    // sweep: exactly NR edges, ignored writes/reserves
    for (int k = 1; k <= NR; k++) begin
      idle();
      if (k == 10) wr(0, 5'd5, 32'h99);
      if (k == 12) rsv(5'd6);
      rd(0, 5'd5);
      rd(1, 5'd6);
      #1;
      push("init_rdy", 0);    pop(64'(rdy_b));
      push("init_rdy_nb", 0); pop(64'(rdy_n));
      if (k % 8 == 1) begin
        push("init_data", 0); pop(pd(data_b, 0));
      end
      @(posedge clk); #1;
      push("init_done", (k == NR) ? 1 : 0); pop(done_b);
    end
    idle();
    push("sweep_done_nb", 1); pop(done_n);
    push("sweep_busy", 0);    pop(busy_b);

    // everything reads zero after the sweep
    for (int r = 0; r < NR; r++) begin
      rd(0, 5'(r));
      rd(1, 5'(NR - 1 - r));
      @(negedge clk);
      push("clr_p0", 0);    pop(pd(data_b, 0));
      push("clr_p1", 0);    pop(pd(data_b, 1));
      push("clr_rdy", 3);   pop(64'(rdy_b));
    end

    // write x5, then attempt x0
    wr(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    m[5] = 32'hDEADBEEF;
    wr(0, 5'd0, 32'h12345678);
    rd(0, 5'd5);
    rd(1, 5'd0);
    #1;
    push("x5", 32'hDEADBEEF);   pop(pd(data_b, 0));
    push("x5_nb", 32'hDEADBEEF); pop(pd(data_n, 0));
    push("x0_byp", 0);          pop(pd(data_b, 1));
    push("x0_rdy", 1);          pop(64'(rdy_b[1]));
    @(negedge clk);
    idle();
    #1;
    push("x0_after", 0); pop(pd(data_b, 1));
    push("busy0", 0);    pop(64'(busy_b[0]));

    // two ports to x7: highest port wins
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'hBBBB);
    rd(0, 5'd7);
    #1;
    push("byp_x7", 32'hBBBB); pop(pd(data_b, 0));
    push("nobyp_x7", 0);      pop(pd(data_n, 0));
    @(negedge clk);
    idle();
    m[7] = 32'hBBBB;
    #1;
    push("st_x7", 32'hBBBB);    pop(pd(data_b, 0));
    push("st_x7_nb", 32'hBBBB); pop(pd(data_n, 0));

    // reserve x9, then release it by write-back
    rsv(5'd9);
    rd(0, 5'd9);
    #1;
    push("pre_rsv_rdy", 1); pop(64'(rdy_b[0]));
    @(negedge clk);
    idle();
    #1;
    push("busy9", 1);    pop(64'(busy_b[9]));
    push("busy9_nb", 1); pop(64'(busy_n[9]));
    push("rdy9", 0);     pop(64'(rdy_b[0]));
    wr(0, 5'd9, 32'h55);
    #1;
    push("rdy9_byp", 1);  pop(64'(rdy_b[0]));
    push("data9_byp", 32'h55); pop(pd(data_b, 0));
    push("rdy9_nb", 0);   pop(64'(rdy_n[0]));
    @(negedge clk);
    idle();
    m[9] = 32'h55;
    #1;
    push("rel9", 0);      pop(64'(busy_b[9]));
    push("rel9_nb", 0);   pop(64'(busy_n[9]));
    push("data9", 32'h55); pop(pd(data_b, 0));
    push("rdy9_rel", 1);  pop(64'(rdy_b[0]));

    // same-cycle reserve and write on x3
    rsv(5'd3);
    wr(0, 5'd3, 32'h3C);
    @(negedge clk);
    idle();
    m[3] = 32'h3C;
    rd(0, 5'd3);
    #1;
    push("busy3", 1);     pop(64'(busy_b[3]));
    push("data3", 32'h3C); pop(pd(data_b, 0));
    push("data3_nb", 32'h3C); pop(pd(data_n, 0));
    push("rdy3", 0);      pop(64'(rdy_b[0]));
    wr(0, 5'd3, 32'h3C);
    @(negedge clk);
    idle();

    // random writes on port 1 against the model
    for (int n = 0; n < 12; n++) begin
      a  = 5'($urandom_range(1, NR - 1));
      d  = $urandom;
      ra = (n % 3 == 0) ? a : 5'($urandom_range(0, NR - 1));
      wr(1, a, d);
      rd(0, ra);
      #1;
      push("rnd_b", (ra == 0) ? 0 : (ra == a) ? d : m[ra]);
      pop(pd(data_b, 0));
      push("rnd_nb", (ra == 0) ? 0 : m[ra]);
      pop(pd(data_n, 0));
      @(negedge clk);
      idle();
      m[a] = d;
    end

    // reset in the middle of RUN with x4 busy
    wr(0, 5'd4, 32'h77);
    rsv(5'd4);
    @(negedge clk);
    idle();
    rd(0, 5'd4);
    #1;
    push("busy4", 1);      pop(64'(busy_b[4]));
    push("data4", 32'h77); pop(pd(data_b, 0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    push("rst2_busy", 0); pop(busy_b);
    push("rst2_done", 0); pop(done_b);
    push("rst2_rdy", 0);  pop(64'(rdy_b));
    for (int k = 1; k <= NR; k++) begin
      @(posedge clk); #1;
      if (k >= NR - 1) begin
        push("rst2_sweep", (k == NR) ? 1 : 0); pop(done_b);
      end
    end
    push("rst2_done_nb", 1); pop(done_n);
    @(negedge clk);
    push("x4_clr", 0);    pop(pd(data_b, 0));
    push("x4_clr_nb", 0); pop(pd(data_n, 0));
    push("x4_rdy", 1);    pop(64'(rdy_b[0]));

    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL sb_leftover: got %0d want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
